// File: rtl/ref_row_fetcher.sv
// Fetches the 15 reference rows of one 8x8 interpolation block and streams them
// through a credit-limited skid FIFO into the filter's transposing shift register.
module ref_row_fetcher #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2,
    parameter int ROWS   = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_rdata,
    output logic [63:0]       row_out,
    output logic              load_L,
    output logic [3:0]        row_idx,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]    ROWS_C   = 4'(ROWS);
    localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] addr, stride_q;
    logic [3:0]        issued, popped;
    logic [CW-1:0]     credits, count;
    logic [RD_LAT-1:0] vpipe;
    logic [63:0]       fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              issue, pop, fifo_wr;

    // Credits count reads not yet popped, so a full FIFO can never be overrun
    // by data already in flight when hold rises.
    assign issue   = (state == FETCH) && !hold && (credits < DEPTH_C) && (issued < ROWS_C);
    assign pop     = (count != '0) && !hold;
    assign fifo_wr = vpipe[RD_LAT-1];

    assign mem_rd_en = issue;
    assign mem_addr  = addr;
    assign load_L    = ~pop;
    assign row_out   = (count != '0) ? fifo_mem[rd_ptr] : 64'h0;
    assign row_idx   = popped;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   if (issue && issued == LAST_ROW) state_nx = DRAIN;
            DRAIN:   if (pop && popped == LAST_ROW) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            stride_q <= '0;
            issued   <= '0;
            popped   <= '0;
            credits  <= '0;
            count    <= '0;
            vpipe    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr     <= base_addr;
                stride_q <= stride;
                issued   <= '0;
                popped   <= '0;
            end else begin
                if (issue) begin
                    addr   <= addr + stride_q;
                    issued <= issued + 1'b1;
                end
                if (pop) popped <= popped + 1'b1;
                if (state == DONE) popped <= '0;
            end

            case ({issue, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase

            case ({fifo_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (fifo_wr) wr_ptr <= next_ptr(wr_ptr);
            if (pop)     rd_ptr <= next_ptr(rd_ptr);

            vpipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
    end

    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_wr && !pop && count == DEPTH_C));

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Directed bench for ref_row_fetcher: a latency-accurate memory model feeds the
// DUT, and every issued address and loaded row is checked against queues.
module tb_ref_row_fetcher;
  localparam int RD_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] stride = '0;
  logic        hold = 1'b0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata;
  logic [63:0] row_out;
  logic        load_L;
  logic [3:0]  row_idx;
  logic        busy;
  logic        done;
  logic [1:0]  fsm_state;

  ref_row_fetcher #(.ADDR_W(16), .RD_LAT(RD_LAT), .ROWS(15)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .stride(stride), .hold(hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .row_out(row_out), .load_L(load_L),
    .row_idx(row_idx), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // memory model: data for a cycle-t request is presented during cycle t+RD_LAT
  function automatic logic [63:0] mem_f(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h0F0F};
  endfunction

  logic        mp_v    [RD_LAT];
  logic [15:0] mp_addr [RD_LAT];
  always @(posedge clock) begin
    mp_v[0]    <= mem_rd_en;
    mp_addr[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      mp_v[i]    <= mp_v[i-1];
      mp_addr[i] <= mp_addr[i-1];
    end
  end
  assign mem_rdata = mp_v[RD_LAT-1] ? mem_f(mp_addr[RD_LAT-1]) : 64'h0;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [15:0] exp_addr_q[$];
  int n_checks = 0;
  int n_err = 0;
  int t0, n_rd, n_ld, n_done, first_rd, first_ld, last_ld, done_rel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic prep(input logic [15:0] b, input logic [15:0] s);
    logic [15:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    for (int r = 0; r < 15; r++) begin
      a = 16'(b + 16'(r) * s);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_f(a));
    end
    n_rd = 0; n_ld = 0; n_done = 0;
    first_rd = -1; first_ld = -1; last_ld = -1; done_rel = -1;
  endtask

  // called at the falling edge of cycle rel of the current block
  task automatic sample(input int rel);
    if (mem_rd_en) begin
      n_rd++;
      if (first_rd < 0) first_rd = rel;
      if (exp_addr_q.size() == 0) check("extra_rd", 64'd1, 64'd0);
      else check("addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
    end
    if (!load_L) begin
      if (first_ld < 0) first_ld = rel;
      last_ld = rel;
      if (exp_q.size() == 0) check("extra_ld", 64'd1, 64'd0);
      else check("row", row_out, exp_q.pop_front());
      check("row_idx", 64'(row_idx), 64'(n_ld));
      n_ld++;
    end
    if (hold) begin
      check("hold_load", 64'(load_L), 64'd1);
      check("hold_rd", 64'(mem_rd_en), 64'd0);
    end
    if (done) begin
      n_done++;
      done_rel = rel;
    end
    if (rel >= 1) check("busy", 64'(busy), 64'd1);
  endtask

  // driver: one block, optional hold window and an ignored start pulse at cycle ign
  task automatic run_block(input logic [15:0] b, input logic [15:0] s, input int hs,
                           input int hl, input int ign, input int exp_done);
    prep(b, s);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; stride = s; t0 = cyc;
    @(negedge clock);
    check("busy_c0", 64'(busy), 64'd0);
    for (int k = 1; k < 200 && done_rel < 0; k++) begin
      @(posedge clock); #1;
      start     = (k == ign);
      base_addr = (k == ign) ? (b ^ 16'h5555) : b;
      stride    = (k == ign) ? 16'h0001 : s;
      hold      = (k >= hs) && (k < hs + hl);
      @(negedge clock);
      sample(cyc - t0);
    end
    hold = 1'b0;
    if (done_rel < 0) check("timeout", 64'd1, 64'd0);
    check("n_rd", 64'(n_rd), 64'd15);
    check("n_ld", 64'(n_ld), 64'd15);
    check("n_done", 64'(n_done), 64'd1);
    check("first_rd", 64'(first_rd), 64'd1);
    check("first_ld", 64'(first_ld), 64'(RD_LAT + 2));
    check("last_ld", 64'(last_ld), 64'(exp_done - 1));
    check("done_cyc", 64'(done_rel), 64'(exp_done));
    check("left_rows", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_load", 64'(load_L), 64'd1);
    check("rst_rd", 64'(mem_rd_en), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_row", row_out, 64'd0);
    check("rst_idx", 64'(row_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // basic fetch, no hold: done at RD_LAT+17
    run_block(16'h0100, 16'h0040, 999, 0, -1, RD_LAT + 17);
    // address wrap
    run_block(16'hFFC0, 16'h0020, 999, 0, -1, RD_LAT + 17);
    // hold for 6 cycles from cycle 5
    run_block(16'h0300, 16'h0010, 5, 6, -1, 25);
    // start during FETCH is ignored
    run_block(16'h0200, 16'h0010, 999, 0, 5, RD_LAT + 17);

    // reset at cycle 8 with reads in flight
    prep(16'h0800, 16'h0008);
    @(posedge clock); #1;
    start = 1'b1; base_addr = 16'h0800; stride = 16'h0008; t0 = cyc;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      reset = (k == 8);
      @(negedge clock);
      if (k <= 8) sample(k);
      else if (k == 9) begin
        check("mid_rst_rd", 64'(mem_rd_en), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_load", 64'(load_L), 64'd1);
        check("mid_rst_row", row_out, 64'd0);
        check("mid_rst_idx", 64'(row_idx), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
      end else begin
        check("post_rst_load", 64'(load_L), 64'd1);
        check("post_rst_rd", 64'(mem_rd_en), 64'd0);
      end
    end
    run_block(16'h1234, 16'h0100, 999, 0, -1, RD_LAT + 17);

    // back-to-back: second start lands in the first IDLE cycle
    run_block(16'h4000, 16'h0080, 999, 0, -1, RD_LAT + 17);
    run_block(16'h5000, 16'hFFF8, 999, 0, -1, RD_LAT + 17);

    @(posedge clock); #1;
    @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_load", 64'(load_L), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
